// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, arbiter state type and write-entry type for the frame-buffer port
package fb_pkg;

  localparam int IMG_W     = 64;
  localparam int IMG_H     = 64;
  localparam int ADDR_W    = 12;
  localparam int H_VISIBLE = 640;
  localparam int V_VISIBLE = 480;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISP,
    S_WRITE
  } fb_state_t;

  // One buffered pixel write; the FIFO stores it as a flat {addr, data} vector
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              data;
  } fb_wr_entry_t;

  // Pack an address/pixel pair into the flat layout the FIFO stores
  function automatic fb_wr_entry_t fb_make_entry(input logic [ADDR_W-1:0] addr, input logic data);
    fb_wr_entry_t e;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - synchronous write FIFO with registered count and full/empty flags
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so a push at full is safe only alongside a pop
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (PW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards all stored entries
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer RAM port arbiter, display reads over buffered writes (optional FB_TEAR_GUARD_EN)
module fb_port_arbiter #(
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              ram_wren,
  input  logic              ram_rdata,
  output logic              pix_valid,
  output logic              pix_data,
  output logic              busy
);

  import fb_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fb_state_t         state;
  fb_state_t         next_state;
  logic              window;
  logic              gate;
  logic [ADDR_W-1:0] disp_addr;
  logic              push;
  logic              pop;
  logic [ADDR_W:0]   head;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              rd_d2;

  assign window    = (counter_x < 10'(IMG_W)) && (counter_y < 10'(IMG_H));
  assign disp_addr = ADDR_W'({counter_y[YW-1:0], counter_x[XW-1:0]});

`ifdef FB_TEAR_GUARD_EN
  // Writes land only in vertical blanking so a frame is never shown half-updated
  assign gate = (counter_y >= 10'(V_VISIBLE));
`else
  assign gate = 1'b1;
`endif

  assign wr_ready = !full;
  assign busy     = !empty;
  assign push     = wr_req && wr_ready;
  assign pop      = (next_state == S_WRITE);

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_W + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_addr, wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Slot decision for this cycle; the window always wins, and empty comes from the registered count so a fresh push never bypasses
  always_comb begin
    next_state = S_IDLE;
    if (window)               next_state = S_DISP;
    else if (!empty && gate)  next_state = S_WRITE;
  end

  // Arbiter FSM and registered RAM pins; idle slots leave the address where it was
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ram_addr  <= '0;
      ram_wdata <= 1'b0;
      ram_wren  <= 1'b0;
    end else begin
      state <= next_state;
      case (next_state)
        S_DISP: begin
          ram_addr <= disp_addr;
          ram_wren <= 1'b0;
        end
        S_WRITE: begin
          ram_addr  <= head[ADDR_W:1];
          ram_wdata <= head[0];
          ram_wren  <= 1'b1;
        end
        default: ram_wren <= 1'b0;
      endcase
    end
  end

  // Read-data alignment: a display slot's data returns a cycle after the address and is captured the cycle after that
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d2     <= 1'b0;
      pix_valid <= 1'b0;
      pix_data  <= 1'b0;
    end else begin
      rd_d2     <= (state == S_DISP);
      pix_valid <= rd_d2;
      pix_data  <= rd_d2 ? ram_rdata : 1'b0;
    end
  end

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb/tb_fb_port_arbiter.sv - self-checking bench for fb_port_arbiter with a queue-based reference model
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  counter_x;
  logic [9:0]  counter_y;
  logic        wr_req;
  logic [11:0] wr_addr;
  logic        wr_data;
  logic        wr_ready;
  logic [11:0] ram_addr;
  logic        ram_wdata;
  logic        ram_wren;
  logic        ram_rdata = 1'b0;
  logic        pix_valid;
  logic        pix_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  fb_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .counter_x (counter_x),
    .counter_y (counter_y),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM, read-first
  bit ram [4096];
  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_wren) ram[ram_addr] <= ram_wdata;
  end

  // Reference model: a queue of pending writes and the image as the writer sees it
  typedef struct packed { logic [11:0] a; logic d; } ent_t;
  ent_t q[$];
  bit   mmem [4096];
  logic [11:0] m_addr = 0;
  logic        m_wdata = 0;
  logic        m_wren = 0;
  bit p1v, p1d, p2v, p2d, m_pv, m_pd;

  always @(posedge clk) begin : model
    int sz;
    bit win;
    bit gt;
    int da;
    ent_t e;
    sz  = q.size();
    win = (counter_x < 64) && (counter_y < 64);
    da  = (counter_y % 64) * 64 + (counter_x % 64);
`ifdef FB_TEAR_GUARD_EN
    gt  = (counter_y >= 480);
`else
    gt  = 1;
`endif
    if (reset) begin
      q.delete();
      m_addr = 0; m_wdata = 0; m_wren = 0;
      p1v = 0; p1d = 0; p2v = 0; p2d = 0; m_pv = 0; m_pd = 0;
    end else begin
      m_pv = p2v; m_pd = p2d;
      p2v  = p1v; p2d  = p1d;
      p1v  = win; p1d  = win ? mmem[da] : 1'b0;
      if (win) begin
        m_addr = 12'(da);
        m_wren = 0;
      end else if (sz > 0 && gt) begin
        e = q.pop_front();
        m_addr  = e.a;
        m_wdata = e.d;
        m_wren  = 1;
        mmem[e.a] = e.d;
      end else begin
        m_wren = 0;
      end
      if (wr_req && sz < 4) begin
        e.a = wr_addr;
        e.d = wr_data;
        q.push_back(e);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ram_wren",  32'(ram_wren),  32'(m_wren));
      chk("ram_addr",  32'(ram_addr),  32'(m_addr));
      chk("ram_wdata", 32'(ram_wdata), 32'(m_wdata));
      chk("wr_ready",  32'(wr_ready),  32'(q.size() < 4));
      chk("busy",      32'(busy),      32'(q.size() != 0));
      chk("pix_valid", 32'(pix_valid), 32'(m_pv));
      chk("pix_data",  32'(pix_data),  32'(m_pd));
    end
  end

  // Log of RAM writes as they appear on the pins
  ent_t wlog[$];
  always @(negedge clk) begin
    ent_t w;
    if (chk_en && ram_wren) begin
      w.a = ram_addr;
      w.d = ram_wdata;
      wlog.push_back(w);
    end
  end

  task automatic step(input int x, input int y);
    counter_x = 10'(x);
    counter_y = 10'(y);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [11:0] exp_a [5];
    logic        exp_d [5];
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = 0;
      mmem[i] = 0;
    end
    ram[12'h0C5]  = 1;
    mmem[12'h0C5] = 1;

    reset = 1; wr_req = 0; wr_addr = 0; wr_data = 0;
    counter_x = 700; counter_y = 500;
    @(posedge clk); #1;
    chk_en = 1;
    step(700, 500);
    chk("rst_wren",  32'(ram_wren),  0);
    chk("rst_addr",  32'(ram_addr),  0);
    chk("rst_ready", 32'(wr_ready),  1);
    chk("rst_busy",  32'(busy),      0);
    chk("rst_pixv",  32'(pix_valid), 0);
    reset = 0;

    // Display fetch at (5,3)
    step(5, 3);
    chk("fetch_addr", 32'(ram_addr), 32'h0C5);
    step(700, 3);
    step(700, 3);
    chk("fetch_pixv", 32'(pix_valid), 1);
    chk("fetch_pixd", 32'(pix_data),  1);
    step(700, 3);
    chk("fetch_pixv_off", 32'(pix_valid), 0);

`ifdef FB_TEAR_GUARD_EN
    for (int i = 0; i < 3; i++) begin
      wr_req = 1; wr_addr = 12'(12'h3F0 + i); wr_data = 1;
      step(300 + i, 100);
    end
    wr_req = 0;
    for (int i = 0; i < 5; i++) step(310 + i, 100);
    chk("tg_hold", 32'(wlog.size()), 0);
    for (int i = 0; i < 3; i++) begin
      step(i, 480);
      chk("tg_wren", 32'(ram_wren), 1);
      chk("tg_addr", 32'(ram_addr), 32'(12'h3F0 + i));
    end
    step(3, 480);
    chk("tg_done", 32'(busy), 0);
`else
    // Priority: write pushed inside the window waits for x=64
    wr_req = 1; wr_addr = 12'h123; wr_data = 1;
    step(60, 10);
    wr_req = 0;
    for (int x = 61; x < 64; x++) begin
      step(x, 10);
      chk("prio_hold", 32'(ram_wren), 0);
    end
    step(64, 10);
    chk("prio_wren", 32'(ram_wren), 1);
    chk("prio_addr", 32'(ram_addr), 32'h123);
    chk("prio_busy", 32'(busy), 0);
    step(35, 4);
    step(700, 4);
    step(700, 4);
    chk("readback", 32'(pix_data), 1);

    // Full FIFO plus a held fifth request
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      wr_req = 1; wr_addr = 12'(12'h200 + i); wr_data = 1'(i & 1);
      step(i, 20);
    end
    chk("full_ready", 32'(wr_ready), 0);
    chk("full_busy",  32'(busy), 1);
    wr_addr = 12'h204; wr_data = 1;
    for (int x = 4; x < 64; x++) step(x, 20);
    chk("full_held",  32'(wr_ready), 0);
    chk("full_nowr",  32'(wlog.size()), 0);
    step(64, 20);
    chk("full_pop1_ready", 32'(wr_ready), 1);
    step(65, 20);
    wr_req = 0;
    chk("full_pushpop_busy", 32'(busy), 1);
    for (int x = 66; x < 71; x++) step(x, 20);
    exp_a = '{12'h200, 12'h201, 12'h202, 12'h203, 12'h204};
    exp_d = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    chk("order_count", 32'(wlog.size()), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk("order_addr", 32'(wlog[i].a), 32'(exp_a[i]));
      chk("order_data", 32'(wlog[i].d), 32'(exp_d[i]));
    end

    // Reset in the middle of a drain
    wlog.delete();
    for (int i = 0; i < 3; i++) begin
      wr_req = 1; wr_addr = 12'(12'h300 + i); wr_data = 1;
      step(10 + i, 30);
    end
    wr_req = 0;
    step(64, 30);
    reset = 1;
    step(65, 30);
    chk("mid_rst_wren",  32'(ram_wren), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_ready", 32'(wr_ready), 1);
    reset = 0;
    for (int x = 66; x < 71; x++) step(x, 30);
    chk("mid_rst_log", 32'(wlog.size()), 1);

    // Horizontal blanking of a visible line is a write slot
    wr_req = 1; wr_addr = 12'h3FF; wr_data = 1;
    step(300, 100);
    wr_req = 0;
    step(301, 100);
    chk("hblank_wren", 32'(ram_wren), 1);
    chk("hblank_addr", 32'(ram_addr), 32'h3FF);
`endif

    step(700, 500);
    step(700, 500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
